// File: rtl/pipe_aes_seq_ctrl_if.sv
// Front-end/AES sequencer bus: run control and hazards in, fetch enables and AES datapath strobes out.
interface pipe_aes_seq_ctrl_if #(
  parameter int RND_W = 4
);
  logic             start;
  logic             branch_taken;
  logic             load_use;
  logic             aes_req;
  logic             pc_en;
  logic             ifid_start;
  logic             aes_load;
  logic             aes_round_en;
  logic [RND_W-1:0] aes_round_idx;
  logic             aes_final;
  logic             aes_wb;
  logic             busy;

  modport master (
    output start, branch_taken, load_use, aes_req,
    input  pc_en, ifid_start, aes_load, aes_round_en, aes_round_idx, aes_final, aes_wb, busy
  );

  modport slave (
    input  start, branch_taken, load_use, aes_req,
    output pc_en, ifid_start, aes_load, aes_round_en, aes_round_idx, aes_final, aes_wb, busy
  );
endinterface

// File: rtl/pipe_aes_seq_ctrl.sv
// Front-end sequencer for the RV32 AES core: PC/IF-ID stall, bubble and flush control,
// plus sequencing of the multi-cycle AES round datapath.
//
// state     | meaning
// IDLE      | front end halted, all outputs 0
// RUN       | normal fetch; stall/flush/AES issue decided combinationally
// AES_LOAD  | load state/key into AES datapath, cnt <= 1
// AES_ROUND | one round per cycle, idx = cnt, final on cnt == NUM_ROUNDS
// AES_WB    | write back AES result and resume fetch
module pipe_aes_seq_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_aes_seq_ctrl_if.slave    bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RUN       = 3'd1;
  localparam logic [2:0] AES_LOAD  = 3'd2;
  localparam logic [2:0] AES_ROUND = 3'd3;
  localparam logic [2:0] AES_WB    = 3'd4;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

  logic [2:0]       r_state;
  logic [RND_W-1:0] r_cnt;
  logic [2:0]       w_state_nxt;
  logic [RND_W-1:0] w_cnt_nxt;
  logic             w_last;

  assign w_last = (r_cnt == LAST_RND);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    bus.pc_en         = 1'b0;
    bus.ifid_start    = 1'b0;
    bus.aes_load      = 1'b0;
    bus.aes_round_en  = 1'b0;
    bus.aes_round_idx = '0;
    bus.aes_final     = 1'b0;
    bus.aes_wb        = 1'b0;
    bus.busy          = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_nxt = RUN;
      end
      RUN: begin
        if (!bus.start) begin
          w_state_nxt = IDLE;
        end else if (bus.branch_taken) begin
          // Redirect wins over a same-cycle AES op: that op is on the wrong path.
          bus.pc_en = 1'b1;
        end else if (bus.aes_req) begin
          w_state_nxt = AES_LOAD;
        end else if (!bus.load_use) begin
          bus.pc_en      = 1'b1;
          bus.ifid_start = 1'b1;
        end
      end
      AES_LOAD: begin
        bus.aes_load = 1'b1;
        bus.busy     = 1'b1;
        w_cnt_nxt    = RND_W'(1);
        w_state_nxt  = AES_ROUND;
      end
      AES_ROUND: begin
        bus.aes_round_en  = 1'b1;
        bus.busy          = 1'b1;
        bus.aes_round_idx = r_cnt;
        bus.aes_final     = w_last;
        // Clear on the last round so cnt never passes NUM_ROUNDS.
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = AES_WB;
        end else begin
          w_cnt_nxt   = r_cnt + RND_W'(1);
        end
      end
      AES_WB: begin
        bus.aes_wb     = 1'b1;
        bus.busy       = 1'b1;
        bus.pc_en      = 1'b1;
        bus.ifid_start = 1'b1;
        w_cnt_nxt      = '0;
        w_state_nxt    = RUN;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Abort: outputs still follow the current state, only the next state is forced.
    if (!bus.start && (r_state == AES_LOAD || r_state == AES_ROUND || r_state == AES_WB)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_pipe_aes_seq_ctrl.sv
// Directed bench for pipe_aes_seq_ctrl: reset, stalls, flush, full AES op, abort and reset mid-op.
module tb_pipe_aes_seq_ctrl;
  localparam int NR = 10;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pipe_aes_seq_ctrl_if #(.RND_W(4)) bus ();

  pipe_aes_seq_ctrl #(.NUM_ROUNDS(NR), .RND_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector: {pc_en, ifid_start, aes_load, aes_round_en, idx[3:0], aes_final, aes_wb, busy}
  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic pc, input logic ifid, input logic ld,
                         input logic ren, input logic [3:0] idx, input logic fin,
                         input logic wb, input logic bsy);
    #1;
    chk(tag, {bus.pc_en, bus.ifid_start, bus.aes_load, bus.aes_round_en, bus.aes_round_idx,
              bus.aes_final, bus.aes_wb, bus.busy},
        {pc, ifid, ld, ren, idx, fin, wb, bsy});
  endtask

  // Enter with aes_req=1 already applied in RUN; leaves the bench in the AES_WB cycle.
  task automatic run_aes(input string tag);
    tick();
    bus.aes_req = 1'b0;
    chk_out({tag, "_load"}, 0, 0, 1, 0, 4'd0, 0, 0, 1);
    for (int r = 1; r <= NR; r++) begin
      tick();
      chk_out($sformatf("%s_rnd%0d", tag, r), 0, 0, 0, 1, 4'(r), (r == NR), 0, 1);
    end
    tick();
    chk_out({tag, "_wb"}, 1, 1, 0, 0, 4'd0, 0, 1, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset            = 1'b0;
    bus.start        = 1'b1;
    bus.branch_taken = 1'b0;
    bus.load_use     = 1'b0;
    bus.aes_req      = 1'b0;

    // Reset held two cycles with start=1
    tick();
    tick();
    chk_out("reset_outs", 0, 0, 0, 0, 4'd0, 0, 0, 0);
    chk("reset_state", 11'(dut.r_state), 11'd0);
    reset = 1'b1;
    tick();
    chk_out("run_after_reset", 1, 1, 0, 0, 4'd0, 0, 0, 0);

    // Single-cycle load-use stall
    bus.load_use = 1'b1;
    chk_out("load_use_stall", 0, 0, 0, 0, 4'd0, 0, 0, 0);
    tick();
    bus.load_use = 1'b0;
    chk_out("load_use_release", 1, 1, 0, 0, 4'd0, 0, 0, 0);

    // Full AES op
    bus.aes_req = 1'b1;
    chk_out("aes_issue", 0, 0, 0, 0, 4'd0, 0, 0, 0);
    run_aes("aes1");
    tick();
    chk_out("aes1_back_run", 1, 1, 0, 0, 4'd0, 0, 0, 0);

    // Branch with same-cycle AES op: flush, op dropped
    bus.branch_taken = 1'b1;
    bus.aes_req      = 1'b1;
    chk_out("branch_flush", 1, 0, 0, 0, 4'd0, 0, 0, 0);
    tick();
    bus.branch_taken = 1'b0;
    bus.aes_req      = 1'b0;
    chk_out("branch_no_load", 1, 1, 0, 0, 4'd0, 0, 0, 0);

    // Abort at round 5 via start=0
    bus.aes_req = 1'b1;
    tick();
    bus.aes_req = 1'b0;
    for (int r = 1; r <= 5; r++) tick();
    bus.start = 1'b0;
    chk_out("abort_rnd5", 0, 0, 0, 1, 4'd5, 0, 0, 1);
    tick();
    chk_out("abort_idle", 0, 0, 0, 0, 4'd0, 0, 0, 0);
    chk("abort_cnt", 11'(dut.r_cnt), 11'd0);
    bus.start = 1'b1;
    tick();
    chk_out("abort_rerun", 1, 1, 0, 0, 4'd0, 0, 0, 0);
    bus.aes_req = 1'b1;
    tick();
    bus.aes_req = 1'b0;
    chk_out("restart_load", 0, 0, 1, 0, 4'd0, 0, 0, 1);
    tick();
    chk_out("restart_rnd1", 0, 0, 0, 1, 4'd1, 0, 0, 1);

    // Reset mid-round
    tick();
    tick();
    chk_out("pre_reset_rnd3", 0, 0, 0, 1, 4'd3, 0, 0, 1);
    reset = 1'b0;
    tick();
    chk_out("midreset_idle", 0, 0, 0, 0, 4'd0, 0, 0, 0);
    chk("midreset_cnt", 11'(dut.r_cnt), 11'd0);
    reset = 1'b1;
    tick();
    chk_out("midreset_run", 1, 1, 0, 0, 4'd0, 0, 0, 0);

    // Back-to-back AES ops
    bus.aes_req = 1'b1;
    run_aes("b2b_a");
    bus.aes_req = 1'b1;
    tick();
    chk_out("b2b_issue", 0, 0, 0, 0, 4'd0, 0, 0, 0);
    run_aes("b2b_b");
    tick();
    chk_out("b2b_back_run", 1, 1, 0, 0, 4'd0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
